// File: rtl/pcie_arb_pkg.sv
// Shared types and default constants for the PCIe C2H stream arbiter family.
package pcie_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    DRAIN = 2'd2
  } arb_state_t;

  localparam int TRUNC_CNT_W    = 16;
  localparam int DEF_DATA_WIDTH = 256;
  localparam int DEF_NUM_PORTS  = 2;
  localparam int DEF_MAX_BEATS  = 64;

endpackage

// File: rtl/rr_arb_pick.sv
// Round-robin pick: first requesting port above last_grant, wrapping to port 0.
// Purely combinational.
module rr_arb_pick #(
  parameter int NUM_PORTS = 2,
  parameter int GW        = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [GW-1:0]        last_grant,
  output logic [GW-1:0]        pick,
  output logic                 any_req
);

  // Ports above last_grant override the wrapped half; within each half the lowest index wins.
  always_comb begin
    pick    = '0;
    any_req = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i] && (GW'(i) <= last_grant)) begin
        pick    = GW'(i);
        any_req = 1'b1;
      end
    end
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (req[i] && (GW'(i) > last_grant)) begin
        pick    = GW'(i);
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pcie_c2h_arbiter.sv
// Packet-granular round-robin mux of NUM_PORTS AXI-Stream requesters onto the C2H stream.
// One-cycle registered output; s_tready follows the output register's room, runaway packets are cut at MAX_BEATS.
module pcie_c2h_arbiter
  import pcie_arb_pkg::*;
#(
  parameter int NUM_PORTS  = DEF_NUM_PORTS,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MAX_BEATS  = DEF_MAX_BEATS
) (
  input  logic                               clk,
  input  logic                               sys_rst,
  input  logic                               driver_ready,
  input  logic [NUM_PORTS-1:0]               s_tvalid,
  output logic [NUM_PORTS-1:0]               s_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]    s_tdata,
  input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]  s_tkeep,
  input  logic [NUM_PORTS-1:0]               s_tlast,
  output logic                               m_tvalid,
  output logic [DATA_WIDTH-1:0]              m_tdata,
  output logic [DATA_WIDTH/8-1:0]            m_tkeep,
  output logic                               m_tlast,
  input  logic                               m_tready,
  output logic [$clog2(NUM_PORTS)-1:0]       grant_id,
  output logic                               busy,
  output logic [TRUNC_CNT_W-1:0]             trunc_cnt
);

  localparam int GW = $clog2(NUM_PORTS);
  localparam int KW = DATA_WIDTH / 8;
  localparam int BW = $clog2(MAX_BEATS + 1);

  arb_state_t            r_state, w_state_nxt;
  logic [GW-1:0]         r_grant, r_last_grant, w_pick;
  logic                  w_any;
  logic [BW-1:0]         r_beat_cnt;
  logic [TRUNC_CNT_W-1:0] r_trunc_cnt;
  logic                  r_m_tvalid, r_m_tlast;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic [KW-1:0]         r_m_tkeep;

  logic                  w_sel_vld, w_sel_lst, w_sel_rdy, w_acc, w_cap, w_at_max, w_out_rdy;
  logic [DATA_WIDTH-1:0] w_sel_dat;
  logic [KW-1:0]         w_sel_keep;

  rr_arb_pick #(
    .NUM_PORTS (NUM_PORTS),
    .GW        (GW)
  ) u_pick (
    .req        (s_tvalid),
    .last_grant (r_last_grant),
    .pick       (w_pick),
    .any_req    (w_any)
  );

  always_comb begin
    w_sel_vld  = 1'b0;
    w_sel_lst  = 1'b0;
    w_sel_dat  = '0;
    w_sel_keep = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == GW'(i)) begin
        w_sel_vld  = s_tvalid[i];
        w_sel_lst  = s_tlast[i];
        w_sel_dat  = s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_keep = s_tkeep[i*KW +: KW];
      end
    end
  end

  assign w_out_rdy = !r_m_tvalid || m_tready;
  assign w_at_max  = (r_beat_cnt == BW'(MAX_BEATS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_sel_rdy   = 1'b0;
    case (r_state)
      IDLE: begin
        if (driver_ready && w_any) w_state_nxt = PASS;
      end
      PASS: begin
        w_sel_rdy = w_out_rdy;
        if (w_sel_vld && w_out_rdy) begin
          if (w_sel_lst)     w_state_nxt = IDLE;
          else if (w_at_max) w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        w_sel_rdy = 1'b1;
        if (w_sel_vld && w_sel_lst) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_acc = w_sel_vld && w_sel_rdy;
  assign w_cap = (r_state == PASS) && w_acc;

  always_comb begin
    s_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (r_grant == GW'(i)) s_tready[i] = w_sel_rdy;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last_grant <= GW'(NUM_PORTS - 1);
      r_beat_cnt   <= '0;
      r_trunc_cnt  <= '0;
      r_m_tvalid   <= 1'b0;
      r_m_tdata    <= '0;
      r_m_tkeep    <= '0;
      r_m_tlast    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && (w_state_nxt == PASS)) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_cap) begin
        r_m_tvalid <= 1'b1;
        r_m_tdata  <= w_sel_dat;
        r_m_tkeep  <= w_sel_keep;
        r_m_tlast  <= w_sel_lst || w_at_max;
        r_beat_cnt <= r_beat_cnt + BW'(1);
      end else if (m_tready) begin
        r_m_tvalid <= 1'b0;
      end
      if (w_cap && (w_sel_lst || w_at_max)) r_last_grant <= r_grant;
      // The cut beat carries a forced tlast; the rest of the packet is swallowed in DRAIN.
      if (w_cap && !w_sel_lst && w_at_max && (r_trunc_cnt != '1))
        r_trunc_cnt <= r_trunc_cnt + TRUNC_CNT_W'(1);
    end
  end

  assign m_tvalid  = r_m_tvalid;
  assign m_tdata   = r_m_tdata;
  assign m_tkeep   = r_m_tkeep;
  assign m_tlast   = r_m_tlast;
  assign grant_id  = r_grant;
  assign busy      = (r_state != IDLE);
  assign trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_pcie_c2h_arbiter.sv
// Directed bench: instance A (2 ports, MAX_BEATS=4) for fairness/backpressure/truncation/gating/reset,
// instance B (4 ports) for the single-requester case.
module tb_pcie_c2h_arbiter;

  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_a, drv_rdy_a;
  logic [1:0]  a_s_tvalid, a_s_tready, a_s_tlast;
  logic [63:0] a_s_tdata;
  logic [7:0]  a_s_tkeep;
  logic        a_m_tvalid, a_m_tready, a_m_tlast;
  logic [31:0] a_m_tdata;
  logic [3:0]  a_m_tkeep;
  logic        a_grant, a_busy;
  logic [15:0] a_trunc;

  logic         rst_b;
  logic [3:0]   b_s_tvalid, b_s_tready, b_s_tlast;
  logic [127:0] b_s_tdata;
  logic [15:0]  b_s_tkeep;
  logic         b_m_tvalid, b_m_tlast;
  logic [31:0]  b_m_tdata;
  logic [3:0]   b_m_tkeep;
  logic [1:0]   b_grant;
  logic         b_busy;
  logic [15:0]  b_trunc;

  pcie_c2h_arbiter #(.NUM_PORTS(2), .DATA_WIDTH(DW), .MAX_BEATS(4)) dut_a (
    .clk(clk), .sys_rst(rst_a), .driver_ready(drv_rdy_a),
    .s_tvalid(a_s_tvalid), .s_tready(a_s_tready), .s_tdata(a_s_tdata),
    .s_tkeep(a_s_tkeep), .s_tlast(a_s_tlast),
    .m_tvalid(a_m_tvalid), .m_tdata(a_m_tdata), .m_tkeep(a_m_tkeep),
    .m_tlast(a_m_tlast), .m_tready(a_m_tready),
    .grant_id(a_grant), .busy(a_busy), .trunc_cnt(a_trunc)
  );

  pcie_c2h_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(DW), .MAX_BEATS(8)) dut_b (
    .clk(clk), .sys_rst(rst_b), .driver_ready(1'b1),
    .s_tvalid(b_s_tvalid), .s_tready(b_s_tready), .s_tdata(b_s_tdata),
    .s_tkeep(b_s_tkeep), .s_tlast(b_s_tlast),
    .m_tvalid(b_m_tvalid), .m_tdata(b_m_tdata), .m_tkeep(b_m_tkeep),
    .m_tlast(b_m_tlast), .m_tready(1'b1),
    .grant_id(b_grant), .busy(b_busy), .trunc_cnt(b_trunc)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] src_dat [2][32];
  logic        src_lst [2][32];
  int          src_len [2];
  int          src_ptr [2];
  bit          src_en  [2];

  logic [31:0] out_dat [64];
  logic        out_lst [64];
  int          out_cyc [64];
  int          out_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int p, input int n, input int b);
    return 32'hA000_0000 | (32'(p) << 16) | (32'(n) << 8) | 32'(b);
  endfunction

  task automatic clear_src();
    for (int p = 0; p < 2; p++) begin
      src_len[p] = 0;
      src_ptr[p] = 0;
      src_en[p]  = 1'b0;
    end
  endtask

  task automatic load(input int p, input int n, input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      src_dat[p][src_len[p]] = mk(p, n, b);
      src_lst[p][src_len[p]] = (b == nbeats - 1);
      src_len[p]++;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < 2; p++) begin
      if (src_en[p] && (src_ptr[p] < src_len[p])) begin
        a_s_tvalid[p]          = 1'b1;
        a_s_tdata[p*DW +: DW]  = src_dat[p][src_ptr[p]];
        a_s_tlast[p]           = src_lst[p][src_ptr[p]];
      end else begin
        a_s_tvalid[p]          = 1'b0;
        a_s_tdata[p*DW +: DW]  = '0;
        a_s_tlast[p]           = 1'b0;
      end
    end
  endtask

  // Observe handshakes mid-cycle, then drive the next cycle's inputs just after the edge.
  task automatic step();
    @(negedge clk);
    for (int p = 0; p < 2; p++)
      if (a_s_tvalid[p] && a_s_tready[p]) src_ptr[p]++;
    if (a_m_tvalid && a_m_tready && (out_n < 64)) begin
      out_dat[out_n] = a_m_tdata;
      out_lst[out_n] = a_m_tlast;
      out_cyc[out_n] = cyc;
      out_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
    drive();
  endtask

  int          bcnt;
  int          b_n;
  logic [31:0] b_out [16];

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; drv_rdy_a = 1'b1; a_m_tready = 1'b1;
    a_s_tvalid = '0; a_s_tdata = '0; a_s_tlast = '0; a_s_tkeep = '1;
    b_s_tvalid = '0; b_s_tdata = '0; b_s_tlast = '0; b_s_tkeep = '1;
    out_n = 0;
    clear_src();
    drive();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_m_tvalid", 32'(a_m_tvalid), 32'd0);
    chk("rst_s_tready", 32'(a_s_tready), 32'd0);
    chk("rst_grant",    32'(a_grant),    32'd0);
    chk("rst_busy",     32'(a_busy),     32'd0);
    chk("rst_trunc",    32'(a_trunc),    32'd0);
    chk("rst_m_tdata",  a_m_tdata,       32'd0);
    chk("rst_m_tlast",  32'(a_m_tlast),  32'd0);
    chk("rst_b_tvalid", 32'(b_m_tvalid), 32'd0);
    @(posedge clk);
    #1;
    rst_a = 1'b0; rst_b = 1'b0;

    // Fairness: two 4-beat packets on each port, alternating, one bubble between packets.
    clear_src();
    load(0, 0, 4); load(0, 1, 4); load(1, 0, 4); load(1, 1, 4);
    src_en[0] = 1'b1; src_en[1] = 1'b1;
    out_n = 0;
    drive();
    repeat (22) step();
    chk("fair_count", 32'(out_n), 32'd16);
    for (int k = 0; k < 16; k++) begin
      chk("fair_data", out_dat[k], mk((k / 4) % 2, k / 8, k % 4));
      chk("fair_last", 32'(out_lst[k]), 32'((k % 4) == 3));
      chk("fair_gap",  32'(out_cyc[k] - out_cyc[0]), 32'((k / 4) * 5 + (k % 4)));
    end
    chk("fair_no_trunc", 32'(a_trunc), 32'd0);

    // Backpressure: m_tready 1,0,0,1 across a 3-beat packet.
    clear_src();
    load(0, 5, 3);
    src_en[0] = 1'b1;
    out_n = 0;
    drive();
    step();
    step();
    a_m_tready = 1'b0;
    step();
    chk("bp_hold0",  a_m_tdata,          mk(0, 5, 0));
    chk("bp_vld",    32'(a_m_tvalid),    32'd1);
    chk("bp_srdy",   32'(a_s_tready),    32'd0);
    chk("bp_keep",   32'(a_m_tkeep),     32'hF);
    step();
    chk("bp_hold1",  a_m_tdata,          mk(0, 5, 0));
    a_m_tready = 1'b1;
    repeat (5) step();
    chk("bp_count", 32'(out_n), 32'd3);
    for (int k = 0; k < 3; k++) begin
      chk("bp_data", out_dat[k], mk(0, 5, k));
      chk("bp_last", 32'(out_lst[k]), 32'(k == 2));
    end
    chk("bp_consumed", 32'(src_ptr[0]), 32'd3);

    // Truncation: 7-beat runaway on port 1 cut at 4, port 0 served next.
    clear_src();
    load(1, 2, 7); load(0, 3, 2);
    src_en[0] = 1'b1; src_en[1] = 1'b1;
    out_n = 0;
    drive();
    repeat (16) step();
    chk("tr_count", 32'(out_n), 32'd6);
    for (int k = 0; k < 4; k++) begin
      chk("tr_data", out_dat[k], mk(1, 2, k));
      chk("tr_last", 32'(out_lst[k]), 32'(k == 3));
    end
    chk("tr_next_data0", out_dat[4], mk(0, 3, 0));
    chk("tr_next_data1", out_dat[5], mk(0, 3, 1));
    chk("tr_next_last",  32'(out_lst[5]), 32'd1);
    chk("tr_cnt",        32'(a_trunc), 32'd1);
    chk("tr_drained",    32'(src_ptr[1]), 32'd7);
    chk("tr_grant",      32'(a_grant), 32'd0);

    // Gating by driver_ready.
    clear_src();
    drv_rdy_a = 1'b0;
    load(0, 4, 3);
    src_en[0] = 1'b1;
    out_n = 0;
    drive();
    for (int i = 0; i < 20; i++) begin
      step();
      chk("gate_srdy", 32'(a_s_tready), 32'd0);
    end
    drv_rdy_a = 1'b1;
    step();
    chk("gate_open", 32'(a_s_tready), 32'd1);
    drv_rdy_a = 1'b0;
    repeat (6) step();
    chk("gate_count", 32'(out_n), 32'd3);
    chk("gate_lastbeat", out_dat[2], mk(0, 4, 2));
    chk("gate_consumed", 32'(src_ptr[0]), 32'd3);
    load(1, 6, 1);
    src_en[1] = 1'b1;
    drive();
    repeat (3) step();
    chk("gate_park", 32'(a_busy), 32'd0);
    drv_rdy_a = 1'b1;
    clear_src();
    drive();

    // Reset in the middle of a 5-beat packet.
    load(0, 7, 5);
    src_en[0] = 1'b1;
    drive();
    step(); step(); step();
    rst_a = 1'b1;
    step();
    chk("mrst_m_tvalid", 32'(a_m_tvalid), 32'd0);
    chk("mrst_s_tready", 32'(a_s_tready), 32'd0);
    chk("mrst_busy",     32'(a_busy),     32'd0);
    chk("mrst_trunc",    32'(a_trunc),    32'd0);
    rst_a = 1'b0;
    clear_src();
    load(0, 8, 1); load(1, 8, 1);
    src_en[0] = 1'b1; src_en[1] = 1'b1;
    out_n = 0;
    drive();
    step();
    chk("mrst_grant",  32'(a_grant),    32'd0);
    chk("mrst_srdy",   32'(a_s_tready), 32'd1);
    repeat (6) step();
    chk("mrst_count",  32'(out_n), 32'd2);
    chk("mrst_first",  out_dat[0], mk(0, 8, 0));
    chk("mrst_second", out_dat[1], mk(1, 8, 0));

    // Single requester on port 3 of a 4-port instance, 2-beat packets back to back.
    bcnt = 0;
    b_n = 0;
    b_s_tvalid = 4'b1000;
    b_s_tdata = '0;
    b_s_tlast = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("b_other_rdy", 32'(b_s_tready & 4'b0111), 32'd0);
      if (b_busy) chk("b_grant", 32'(b_grant), 32'd3);
      if (b_s_tvalid[3] && b_s_tready[3]) bcnt++;
      if (b_m_tvalid && (b_n < 16)) begin
        b_out[b_n] = b_m_tdata;
        b_n++;
      end
      @(posedge clk);
      #1;
      b_s_tdata[127:96] = 32'(bcnt);
      b_s_tlast = {bcnt[0], 3'b000};
    end
    chk("b_accepted", 32'(bcnt), 32'd6);
    chk("b_out_count", 32'(b_n), 32'd6);
    for (int k = 0; k < 6; k++) chk("b_out_data", b_out[k], 32'(k));
    chk("b_grant_final", 32'(b_grant), 32'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
